// File: rtl/player_controller_if.sv
// rtl/player_controller_if.sv - world map read port shared by the player controller and the map RAM
interface player_controller_if;
  logic       map_rd;
  logic [3:0] map_tx;
  logic [3:0] map_ty;
  logic       map_wall;

  modport master (output map_rd, output map_tx, output map_ty, input map_wall);
  modport slave  (input map_rd, input map_tx, input map_ty, output map_wall);
endinterface

// File: rtl/player_controller.sv
// rtl/player_controller.sv - per-frame player pose update with per-axis wall collision
module player_controller #(
  parameter logic [15:0] START_X     = 16'h0180,
  parameter logic [15:0] START_Y     = 16'h0180,
  parameter logic [8:0]  START_ANGLE = 9'd0,
  parameter logic [8:0]  ROT_STEP    = 9'd15,
  parameter logic [15:0] MOVE_SPEED  = 16'h0020
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic                       btn_fwd,
  input  logic                       btn_back,
  input  logic                       btn_left,
  input  logic                       btn_right,
  player_controller_if.master        map,
  output logic [15:0]                player_x,
  output logic [15:0]                player_y,
  output logic [8:0]                 player_angle,
  output logic                       busy,
  output logic                       update_done
);
  typedef enum logic [2:0] {IDLE, ROT, VEC, RDX, RDY, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         btn_q, btn_d;
  logic [8:0]         ang_q, ang_d, pa_q, pa_d;
  logic signed [17:0] dx_q, dx_d, dy_q, dy_d;
  logic [15:0]        c_q, c_d, nx_q, nx_d, px_q, px_d, py_q, py_d;
  logic               blk_q, blk_d, skip_q, skip_d, done_q, done_d;
  logic [3:0]         tx_q, tx_d, ty_q, ty_d;

  logic [9:0]         sum10;
  logic [4:0]         k, ks;
  logic signed [9:0]  cv, sv;
  logic signed [26:0] pcx, pcy;
  logic signed [17:0] cx, cy;
  logic               acc_ok, rd;
  logic [15:0]        x_acc;

  // Q1.8 cosine at 15-degree steps; sine is the same table offset by 18 entries
  function automatic logic signed [9:0] cos_tab(input logic [4:0] idx);
    case (idx)
      5'd0:  cos_tab = 10'sd256;   5'd1:  cos_tab = 10'sd247;
      5'd2:  cos_tab = 10'sd222;   5'd3:  cos_tab = 10'sd181;
      5'd4:  cos_tab = 10'sd128;   5'd5:  cos_tab = 10'sd66;
      5'd6:  cos_tab = 10'sd0;     5'd7:  cos_tab = -10'sd66;
      5'd8:  cos_tab = -10'sd128;  5'd9:  cos_tab = -10'sd181;
      5'd10: cos_tab = -10'sd222;  5'd11: cos_tab = -10'sd247;
      5'd12: cos_tab = -10'sd256;  5'd13: cos_tab = -10'sd247;
      5'd14: cos_tab = -10'sd222;  5'd15: cos_tab = -10'sd181;
      5'd16: cos_tab = -10'sd128;  5'd17: cos_tab = -10'sd66;
      5'd18: cos_tab = 10'sd0;     5'd19: cos_tab = 10'sd66;
      5'd20: cos_tab = 10'sd128;   5'd21: cos_tab = 10'sd181;
      5'd22: cos_tab = 10'sd222;   5'd23: cos_tab = 10'sd247;
      default: cos_tab = 10'sd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    ang_d   = ang_q;
    pa_d    = pa_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    c_d     = c_q;
    nx_d    = nx_q;
    px_d    = px_q;
    py_d    = py_q;
    blk_d   = blk_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    ty_d    = ty_q;
    rd      = 1'b0;

    sum10  = {1'b0, pa_q} + {1'b0, ROT_STEP};
    k      = 5'(ang_q / 9'd15);
    ks     = (k >= 5'd6) ? k - 5'd6 : k + 5'd18;
    cv     = cos_tab(k);
    sv     = cos_tab(ks);
    pcx    = cv * $signed({1'b0, MOVE_SPEED});
    pcy    = sv * $signed({1'b0, MOVE_SPEED});
    cx     = $signed({2'b00, px_q}) + dx_q;
    cy     = $signed({2'b00, py_q}) + dy_q;
    // map_wall answers the read issued in the previous state, for whichever axis that was
    acc_ok = !blk_q && (skip_q || !map.map_wall);
    x_acc  = acc_ok ? c_q : px_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          btn_d   = {btn_fwd, btn_back, btn_left, btn_right};
          state_d = ROT;
        end
      end
      ROT: begin
        ang_d = pa_q;
        if (btn_q[1:0] == 2'b01)
          ang_d = (sum10 >= 10'd360) ? 9'(sum10 - 10'd360) : sum10[8:0];
        else if (btn_q[1:0] == 2'b10)
          ang_d = (pa_q < ROT_STEP) ? 9'({1'b0, pa_q} + 10'd360 - {1'b0, ROT_STEP})
                                    : pa_q - ROT_STEP;
        state_d = VEC;
      end
      VEC: begin
        dx_d = 18'sd0;
        dy_d = 18'sd0;
        if (btn_q[3:2] == 2'b10) begin
          dx_d = pcx[25:8];
          dy_d = pcy[25:8];
        end else if (btn_q[3:2] == 2'b01) begin
          dx_d = -pcx[25:8];
          dy_d = -pcy[25:8];
        end
        state_d = RDX;
      end
      RDX: begin
        skip_d = (dx_q == 18'sd0);
        blk_d  = !skip_d && (cx[17] || cx[16] || (cx[15:12] != 4'd0));
        c_d    = cx[15:0];
        if (!blk_d && !skip_d) begin
          rd   = 1'b1;
          tx_d = cx[11:8];
          ty_d = py_q[11:8];
        end
        state_d = RDY;
      end
      RDY: begin
        nx_d   = x_acc;
        skip_d = (dy_q == 18'sd0);
        blk_d  = !skip_d && (cy[17] || cy[16] || (cy[15:12] != 4'd0));
        c_d    = cy[15:0];
        if (!blk_d && !skip_d) begin
          rd   = 1'b1;
          tx_d = x_acc[11:8];
          ty_d = cy[11:8];
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        px_d    = nx_q;
        py_d    = acc_ok ? c_q : py_q;
        pa_d    = ang_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      btn_q   <= 4'd0;
      ang_q   <= START_ANGLE;
      pa_q    <= START_ANGLE;
      dx_q    <= 18'sd0;
      dy_q    <= 18'sd0;
      c_q     <= 16'd0;
      nx_q    <= 16'd0;
      px_q    <= START_X;
      py_q    <= START_Y;
      blk_q   <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 4'd0;
      ty_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      ang_q   <= ang_d;
      pa_q    <= pa_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      c_q     <= c_d;
      nx_q    <= nx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      blk_q   <= blk_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
    end
  end

  assign map.map_rd   = rd;
  assign map.map_tx   = tx_d;
  assign map.map_ty   = ty_d;
  assign player_x     = px_q;
  assign player_y     = py_q;
  assign player_angle = pa_q;
  assign busy         = (state_q != IDLE);
  assign update_done  = done_q;
endmodule

// File: tb/tb_player_controller.sv
// tb/tb_player_controller.sv - directed self-checking bench for player_controller
module tb_player_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_fwd = 1'b0, btn_back = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [15:0] player_x, player_y;
  logic [8:0]  player_angle;
  logic        busy, update_done;
  logic [255:0] walls = '0;
  int checks = 0;
  int errors = 0;
  int last_rd = 0;
  int cnt;

  player_controller_if mif();

  player_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_fwd(btn_fwd), .btn_back(btn_back), .btn_left(btn_left), .btn_right(btn_right),
    .map(mif.master),
    .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
    .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  // map RAM model: one-cycle read latency, indexed {row, column}
  always @(posedge clk)
    mif.map_wall <= (rst_n && mif.map_rd) ? walls[{mif.map_ty, mif.map_tx}] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic frame(input logic f, input logic b, input logic l, input logic r, input string tag);
    int lat;
    int rdc;
    @(posedge clk); #1;
    btn_fwd = f; btn_back = b; btn_left = l; btn_right = r;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    lat = 0;
    rdc = 0;
    while (!update_done && lat < 20) begin
      if (mif.map_rd) rdc++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    last_rd = rdc;
    btn_fwd = 1'b0; btn_back = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_x", player_x, 16'h0180);
    chk("rst_y", player_y, 16'h0180);
    chk("rst_angle", player_angle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_map_rd", mif.map_rd, 0);

    frame(1, 0, 0, 0, "fwd0");
    chk("fwd0_x", player_x, 16'h01A0);
    chk("fwd0_y", player_y, 16'h0180);
    chk("fwd0_reads", last_rd, 1);

    frame(0, 0, 1, 0, "left");
    chk("left_angle", player_angle, 345);
    chk("left_x_hold", player_x, 16'h01A0);
    frame(0, 0, 0, 1, "right");
    chk("right_wrap_angle", player_angle, 0);
    frame(0, 0, 1, 1, "both");
    chk("both_angle", player_angle, 0);

    // heading 90, wall at column 1 row 2
    do_reset();
    walls = '0;
    walls[{4'd2, 4'd1}] = 1'b1;
    for (int i = 0; i < 6; i++) frame(0, 0, 0, 1, "rot90");
    chk("rot90_angle", player_angle, 90);
    for (int i = 0; i < 3; i++) frame(1, 0, 0, 0, "up");
    chk("up3_y", player_y, 16'h01E0);
    chk("up3_x", player_x, 16'h0180);
    frame(1, 0, 0, 0, "upwall");
    chk("upwall_y", player_y, 16'h01E0);
    chk("upwall_reads", last_rd, 1);

    // heading 45, wall at column 2 row 1 only blocks the X step
    do_reset();
    walls = '0;
    walls[{4'd1, 4'd2}] = 1'b1;
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 1, "rot45");
    chk("rot45_angle", player_angle, 45);
    for (int i = 0; i < 5; i++) frame(1, 0, 0, 0, "diag");
    chk("diag5_x", player_x, 16'h01EE);
    chk("diag5_y", player_y, 16'h01EE);
    frame(1, 0, 0, 0, "slide");
    chk("slide_x", player_x, 16'h01EE);
    chk("slide_y", player_y, 16'h0204);
    chk("slide_reads", last_rd, 2);

    // heading 180 toward the left map edge
    do_reset();
    walls = '0;
    for (int i = 0; i < 12; i++) frame(0, 0, 0, 1, "rot180");
    chk("rot180_angle", player_angle, 180);
    for (int i = 0; i < 12; i++) frame(1, 0, 0, 0, "west");
    chk("west12_x", player_x, 16'h0000);
    frame(1, 0, 0, 0, "edge");
    chk("edge_x", player_x, 16'h0000);
    chk("edge_y", player_y, 16'h0180);
    chk("edge_reads", last_rd, 0);

    // frame_tick while busy must not start another update
    do_reset();
    @(posedge clk); #1 btn_fwd = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    chk("tick_busy", busy, 1);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (update_done) cnt++;
      @(posedge clk); #1;
    end
    btn_fwd = 1'b0;
    chk("tick_busy_dones", cnt, 1);
    chk("tick_busy_x", player_x, 16'h01A0);

    // reset in the RDY cycle aborts the update
    @(posedge clk); #1 btn_fwd = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_x", player_x, 16'h0180);
    chk("abort_busy", busy, 0);
    rst_n = 1'b1;
    btn_fwd = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (update_done) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_dones", cnt, 0);
    chk("abort_y", player_y, 16'h0180);

    // rotate into 270 and step back in the same frame
    do_reset();
    for (int i = 0; i < 5; i++) frame(0, 0, 1, 0, "rot285");
    chk("rot285_angle", player_angle, 285);
    frame(0, 1, 1, 0, "back270");
    chk("back270_angle", player_angle, 270);
    chk("back270_y", player_y, 16'h01A0);
    chk("back270_x", player_x, 16'h0180);
    chk("back270_reads", last_rd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
